stk_pipe_wrbk: RTL and testbench
================================

Name: stk_pipe_wrbk

Overview:
Writeback (WRBK) stage of the stack pipeline. It terminates the WRBK microcode produced by the memory stage and applies the resolved head/tail pointers to the per-engine head/tail table. It also buffers completion responses, including POP data, in a response FIFO drained by a valid/ready handshake. It exports a backpressure indication so the issue stage stops admitting commands before the FIFO can overflow.

Parameters:
RSP_FIFO_N, 4, response FIFO depth (power of two, >=2)
SKID_N, 2, in-flight commands upstream of WRBK that may still arrive after o_rsp_full_r asserts (SKID_N < RSP_FIFO_N)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
i_wrbk_uc_vld_w  in  1  WRBK microcode valid
i_wrbk_uc_engid_w  in  stk_pkg::engid_t  engine id
i_wrbk_uc_status_w  in  stk_pkg::status_t  command status
i_wrbk_uc_opcode_w  in  stk_pkg::opcode_t  command opcode
i_wrbk_uc_islast_w  in  1  final microcode beat of command
i_wrbk_uc_head_vld_w  in  1  head valid
i_wrbk_uc_head_ptr_w  in  stk_pkg::ptr_t  resolved head pointer
i_wrbk_uc_tail_vld_w  in  1  tail valid
i_wrbk_uc_tail_ptr_w  in  stk_pkg::ptr_t  tail pointer
i_wrbk_uc_dat_vld  in  1  data valid (POP)
i_wrbk_uc_dat_w  in  128  POP data
o_ht_wr_vld_r  out  1  head/tail table write strobe
o_ht_wr_engid_r  out  stk_pkg::engid_t  table index
o_ht_wr_head_vld_r / o_ht_wr_head_ptr_r  out  1 / stk_pkg::ptr_t  new head
o_ht_wr_tail_vld_r / o_ht_wr_tail_ptr_r  out  1 / stk_pkg::ptr_t  new tail
o_eng_done_vld_r  out  1  engine-release pulse
o_eng_done_engid_r  out  stk_pkg::engid_t  released engine
o_rsp_vld_r  out  1  response valid
i_rsp_rdy  in  1  response accept
o_rsp_engid_r, o_rsp_opcode_r, o_rsp_status_r  out  pkg types  response header
o_rsp_dat_vld_r / o_rsp_dat_r  out  1 / 128  response data
o_rsp_full_r  out  1  backpressure to issue stage
o_err_ovf_r  out  1  sticky overflow error

Behaviour:
- Reset: all *_vld_r, o_rsp_full_r, o_err_ovf_r = 0; FIFO empty; read/write pointers = 0. Data fields are don't-care. Reset mid-operation discards FIFO contents and the in-flight WRBK beat.
- Stage register: i_wrbk_uc_* is sampled at the end of cycle C. The valid flop is reset; field flops are enabled by valid.
- Cycle C+1, table write: o_ht_wr_vld_r = vld & (status == STATUS_OK). The remaining o_ht_* fields are the captured fields. This is a one-cycle pulse per beat; every beat writes, not only islast.
- Cycle C+1, engine release: o_eng_done_vld_r = vld & islast, with o_eng_done_engid_r = engid. Released regardless of status.
- Response push: at the end of C+1, if vld & islast, push {engid, opcode, status, dat_vld, dat}. dat is forced to 0 when dat_vld = 0.
- Response pop: o_rsp_vld_r = !empty and presents the head entry. The entry is popped on o_rsp_vld_r & i_rsp_rdy. There is no bypass: the earliest o_rsp_vld_r is cycle C+2.
- Simultaneous push and pop: allowed at any occupancy, including full. The count is unchanged and entry order is preserved.
- Overflow: a push while count == RSP_FIFO_N with no same-cycle pop drops the entry and sets o_err_ovf_r, which stays set until reset. FIFO state is unchanged.
- Backpressure: o_rsp_full_r is registered and = (next_count >= RSP_FIFO_N - SKID_N).
- Pointers: log2(RSP_FIFO_N)+1 bits with a wrap bit. full = MSBs differ & LSBs equal; empty = pointers equal.

Test Plan:
- Single POP beat (engid=2, islast=1, status OK, dat=128'hA5..): o_ht_wr_vld_r and o_eng_done_vld_r pulse in C+1; o_rsp_vld_r in C+2 with dat_vld=1 and dat=A5..; i_rsp_rdy=1 gives one response only.
- PUSH with 3 beats (islast only on the third), status OK: three o_ht_wr pulses; one response with dat_vld=0 and dat=0.
- Status != OK, islast=1: no o_ht_wr_vld_r; o_eng_done_vld_r=1; response carries the status.
- i_rsp_rdy=0 with 4 islast beats at RSP_FIFO_N=4, SKID_N=2: o_rsp_full_r=1 after the 2nd push; count reaches 4; responses drain in order with engid 0,1,2,3.
- FIFO full plus a 5th push with rdy=0: entry dropped, o_err_ovf_r=1 and sticky. Repeat with rdy=1 in the same cycle: no error, count stays 4.
- arst_n asserted with 3 entries queued: o_rsp_vld_r=0 immediately. After release, the first new push appears in C+2.

Source files
------------

// File: rtl/stk_pipe_wrbk.sv
// stk_pkg: shared stack-pipeline field types.
// stk_pipe_wrbk: writeback stage of the stack pipeline.
//   - Registers the WRBK microcode beat (i_wrbk_uc_*).
//   - One cycle later it emits a head/tail table write (o_ht_wr_*) for every
//     beat whose status is OK, and an engine-release pulse (o_eng_done_*) on
//     the final beat of each command.
//   - Final beats push a response {engid, opcode, status, dat_vld, dat} into a
//     RSP_FIFO_N-deep FIFO that is drained through o_rsp_vld_r / i_rsp_rdy.
//   - o_rsp_full_r tells the issue stage to stop admitting commands early
//     enough to absorb SKID_N in-flight commands.
//   - o_err_ovf_r is a sticky flag set when a response had to be dropped.
package stk_pkg;
  typedef logic [3:0] engid_t;
  typedef logic [7:0] ptr_t;
  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_PEEK = 2'd2,
    OP_CLR  = 2'd3
  } opcode_t;
  typedef enum logic [1:0] {
    STATUS_OK    = 2'd0,
    STATUS_EMPTY = 2'd1,
    STATUS_FULL  = 2'd2,
    STATUS_ERR   = 2'd3
  } status_t;
endpackage

module stk_pipe_wrbk
  import stk_pkg::*;
#(
  parameter int unsigned RSP_FIFO_N = 4,
  parameter int unsigned SKID_N     = 2
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           i_wrbk_uc_vld_w,
  input  engid_t         i_wrbk_uc_engid_w,
  input  status_t        i_wrbk_uc_status_w,
  input  opcode_t        i_wrbk_uc_opcode_w,
  input  logic           i_wrbk_uc_islast_w,
  input  logic           i_wrbk_uc_head_vld_w,
  input  ptr_t           i_wrbk_uc_head_ptr_w,
  input  logic           i_wrbk_uc_tail_vld_w,
  input  ptr_t           i_wrbk_uc_tail_ptr_w,
  input  logic           i_wrbk_uc_dat_vld,
  input  logic [127:0]   i_wrbk_uc_dat_w,
  output logic           o_ht_wr_vld_r,
  output engid_t         o_ht_wr_engid_r,
  output logic           o_ht_wr_head_vld_r,
  output ptr_t           o_ht_wr_head_ptr_r,
  output logic           o_ht_wr_tail_vld_r,
  output ptr_t           o_ht_wr_tail_ptr_r,
  output logic           o_eng_done_vld_r,
  output engid_t         o_eng_done_engid_r,
  output logic           o_rsp_vld_r,
  input  logic           i_rsp_rdy,
  output engid_t         o_rsp_engid_r,
  output opcode_t        o_rsp_opcode_r,
  output status_t        o_rsp_status_r,
  output logic           o_rsp_dat_vld_r,
  output logic [127:0]   o_rsp_dat_r,
  output logic           o_rsp_full_r,
  output logic           o_err_ovf_r
);

  localparam int unsigned AW = $clog2(RSP_FIFO_N);

  typedef struct packed {
    engid_t       engid;
    opcode_t      opcode;
    status_t      status;
    logic         dat_vld;
    logic [127:0] dat;
  } rsp_t;

  // Stage valids (reset) and captured beat fields (enabled, not reset).
  logic ht_vld_d, ht_vld_q;
  logic done_vld_d, done_vld_q;
  logic head_vld_q, tail_vld_q;
  ptr_t head_ptr_q, tail_ptr_q;
  rsp_t entry_d, entry_q;

  // Response FIFO.
  rsp_t          mem_q [RSP_FIFO_N];
  logic [AW:0]   wr_ptr_d, wr_ptr_q;
  logic [AW:0]   rd_ptr_d, rd_ptr_q;
  logic [AW:0]   cnt_d;
  logic          empty, full, pop, push_ok;
  logic          rsp_full_d, rsp_full_q;
  logic          ovf_d, ovf_q;

  always_comb begin
    ht_vld_d       = i_wrbk_uc_vld_w && (i_wrbk_uc_status_w == STATUS_OK);
    done_vld_d     = i_wrbk_uc_vld_w && i_wrbk_uc_islast_w;
    entry_d.engid   = i_wrbk_uc_engid_w;
    entry_d.opcode  = i_wrbk_uc_opcode_w;
    entry_d.status  = i_wrbk_uc_status_w;
    entry_d.dat_vld = i_wrbk_uc_dat_vld;
    entry_d.dat     = i_wrbk_uc_dat_vld ? i_wrbk_uc_dat_w : '0;
  end

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop   = !empty && i_rsp_rdy;
    // When full, a same-cycle pop frees the slot being written (wr == rd index),
    // so the push is still accepted and order is preserved.
    push_ok    = done_vld_q && (!full || pop);
    ovf_d      = ovf_q || (done_vld_q && full && !pop);
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    cnt_d      = wr_ptr_d - rd_ptr_d;
    rsp_full_d = (cnt_d >= (AW+1)'(RSP_FIFO_N - SKID_N));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ht_vld_q   <= 1'b0;
      done_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rsp_full_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ht_vld_q   <= ht_vld_d;
      done_vld_q <= done_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rsp_full_q <= rsp_full_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wrbk_uc_vld_w) begin
      entry_q    <= entry_d;
      head_vld_q <= i_wrbk_uc_head_vld_w;
      head_ptr_q <= i_wrbk_uc_head_ptr_w;
      tail_vld_q <= i_wrbk_uc_tail_vld_w;
      tail_ptr_q <= i_wrbk_uc_tail_ptr_w;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= entry_q;
    end
  end

  assign o_ht_wr_vld_r      = ht_vld_q;
  assign o_ht_wr_engid_r    = entry_q.engid;
  assign o_ht_wr_head_vld_r = head_vld_q;
  assign o_ht_wr_head_ptr_r = head_ptr_q;
  assign o_ht_wr_tail_vld_r = tail_vld_q;
  assign o_ht_wr_tail_ptr_r = tail_ptr_q;
  assign o_eng_done_vld_r   = done_vld_q;
  assign o_eng_done_engid_r = entry_q.engid;

  assign o_rsp_vld_r     = !empty;
  assign o_rsp_engid_r   = mem_q[rd_ptr_q[AW-1:0]].engid;
  assign o_rsp_opcode_r  = mem_q[rd_ptr_q[AW-1:0]].opcode;
  assign o_rsp_status_r  = mem_q[rd_ptr_q[AW-1:0]].status;
  assign o_rsp_dat_vld_r = mem_q[rd_ptr_q[AW-1:0]].dat_vld;
  assign o_rsp_dat_r     = mem_q[rd_ptr_q[AW-1:0]].dat;
  assign o_rsp_full_r    = rsp_full_q;
  assign o_err_ovf_r     = ovf_q;

endmodule

// File: tb/tb_stk_pipe_wrbk.sv
// Testbench for stk_pipe_wrbk: directed beats, a queue-based reference model
// checked every cycle on the falling edge, plus literal expectations.
module tb_stk_pipe_wrbk;
  import stk_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned SKID = 2;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         i_vld, i_islast, i_hv, i_tv, i_dv, i_rdy;
  engid_t       i_engid;
  status_t      i_status;
  opcode_t      i_opcode;
  ptr_t         i_hp, i_tp;
  logic [127:0] i_dat;

  logic         o_ht_wr_vld_r, o_ht_wr_head_vld_r, o_ht_wr_tail_vld_r;
  engid_t       o_ht_wr_engid_r, o_eng_done_engid_r, o_rsp_engid_r;
  ptr_t         o_ht_wr_head_ptr_r, o_ht_wr_tail_ptr_r;
  logic         o_eng_done_vld_r, o_rsp_vld_r, o_rsp_dat_vld_r;
  opcode_t      o_rsp_opcode_r;
  status_t      o_rsp_status_r;
  logic [127:0] o_rsp_dat_r;
  logic         o_rsp_full_r, o_err_ovf_r;

  stk_pipe_wrbk #(.RSP_FIFO_N(N), .SKID_N(SKID)) dut (
    .clk(clk), .arst_n(arst_n),
    .i_wrbk_uc_vld_w(i_vld), .i_wrbk_uc_engid_w(i_engid),
    .i_wrbk_uc_status_w(i_status), .i_wrbk_uc_opcode_w(i_opcode),
    .i_wrbk_uc_islast_w(i_islast),
    .i_wrbk_uc_head_vld_w(i_hv), .i_wrbk_uc_head_ptr_w(i_hp),
    .i_wrbk_uc_tail_vld_w(i_tv), .i_wrbk_uc_tail_ptr_w(i_tp),
    .i_wrbk_uc_dat_vld(i_dv), .i_wrbk_uc_dat_w(i_dat),
    .o_ht_wr_vld_r(o_ht_wr_vld_r), .o_ht_wr_engid_r(o_ht_wr_engid_r),
    .o_ht_wr_head_vld_r(o_ht_wr_head_vld_r), .o_ht_wr_head_ptr_r(o_ht_wr_head_ptr_r),
    .o_ht_wr_tail_vld_r(o_ht_wr_tail_vld_r), .o_ht_wr_tail_ptr_r(o_ht_wr_tail_ptr_r),
    .o_eng_done_vld_r(o_eng_done_vld_r), .o_eng_done_engid_r(o_eng_done_engid_r),
    .o_rsp_vld_r(o_rsp_vld_r), .i_rsp_rdy(i_rdy),
    .o_rsp_engid_r(o_rsp_engid_r), .o_rsp_opcode_r(o_rsp_opcode_r),
    .o_rsp_status_r(o_rsp_status_r), .o_rsp_dat_vld_r(o_rsp_dat_vld_r),
    .o_rsp_dat_r(o_rsp_dat_r), .o_rsp_full_r(o_rsp_full_r), .o_err_ovf_r(o_err_ovf_r)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    engid_t       engid;
    opcode_t      opcode;
    status_t      status;
    logic         dat_vld;
    logic [127:0] dat;
  } rsp_m_t;

  rsp_m_t m_q[$];
  rsp_m_t m_ent;
  logic   m_ht_vld, m_done, m_full, m_ovf;
  engid_t m_engid;
  logic   m_hv, m_tv;
  ptr_t   m_hp, m_tp;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_q.delete();
      m_ht_vld = 1'b0;
      m_done   = 1'b0;
      m_full   = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      int  pre;
      logic pop;
      pre = m_q.size();
      pop = (pre > 0) && i_rdy;
      if (pop) void'(m_q.pop_front());
      if (m_done) begin
        if (pre == N && !pop) m_ovf = 1'b1;
        else m_q.push_back(m_ent);
      end
      m_full   = (m_q.size() >= N - SKID);
      m_ht_vld = i_vld && (i_status == STATUS_OK);
      m_done   = i_vld && i_islast;
      if (i_vld) begin
        m_engid = i_engid;
        m_hv = i_hv; m_hp = i_hp; m_tv = i_tv; m_tp = i_tp;
        m_ent.engid   = i_engid;
        m_ent.opcode  = i_opcode;
        m_ent.status  = i_status;
        m_ent.dat_vld = i_dv;
        m_ent.dat     = i_dv ? i_dat : 128'h0;
      end
    end
  end

  // ---------------- per-cycle compare + observation ----------------
  int     ht_cnt = 0;
  rsp_m_t acc_q[$];

  always @(negedge clk) begin
    chk("ht_vld", o_ht_wr_vld_r, m_ht_vld);
    if (m_ht_vld) begin
      chk("ht_engid", o_ht_wr_engid_r, m_engid);
      chk("ht_head_vld", o_ht_wr_head_vld_r, m_hv);
      chk("ht_head_ptr", o_ht_wr_head_ptr_r, m_hp);
      chk("ht_tail_vld", o_ht_wr_tail_vld_r, m_tv);
      chk("ht_tail_ptr", o_ht_wr_tail_ptr_r, m_tp);
    end
    chk("done_vld", o_eng_done_vld_r, m_done);
    if (m_done) chk("done_engid", o_eng_done_engid_r, m_engid);
    chk("rsp_vld", o_rsp_vld_r, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("rsp_engid", o_rsp_engid_r, m_q[0].engid);
      chk("rsp_opcode", o_rsp_opcode_r, m_q[0].opcode);
      chk("rsp_status", o_rsp_status_r, m_q[0].status);
      chk("rsp_dat_vld", o_rsp_dat_vld_r, m_q[0].dat_vld);
      chk("rsp_dat", o_rsp_dat_r, m_q[0].dat);
    end
    chk("rsp_full", o_rsp_full_r, m_full);
    chk("err_ovf", o_err_ovf_r, m_ovf);
    if (o_ht_wr_vld_r) ht_cnt++;
    if (o_rsp_vld_r && i_rdy) begin
      rsp_m_t r;
      r.engid = o_rsp_engid_r; r.opcode = o_rsp_opcode_r; r.status = o_rsp_status_r;
      r.dat_vld = o_rsp_dat_vld_r; r.dat = o_rsp_dat_r;
      acc_q.push_back(r);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    i_vld = 1'b0; i_islast = 1'b0; i_hv = 1'b0; i_tv = 1'b0; i_dv = 1'b0;
    i_engid = '0; i_status = STATUS_OK; i_opcode = OP_PUSH;
    i_hp = '0; i_tp = '0; i_dat = '0;
  endtask

  // Present one beat; returns #1 after the edge that samples it (inputs still driven).
  task automatic beat(input engid_t e, input opcode_t op, input status_t st,
                      input logic last, input logic dv, input logic [127:0] d);
    i_vld = 1'b1; i_engid = e; i_opcode = op; i_status = st; i_islast = last;
    i_dv = dv; i_dat = d;
    i_hv = 1'b1; i_hp = ptr_t'(8'h10 + e); i_tv = e[0]; i_tp = ptr_t'(8'h80 + e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ht_base;
    logic [127:0] a5;
    engid_t exp_ord [5];
    a5 = {16{8'hA5}};
    exp_ord[0] = 4'd0; exp_ord[1] = 4'd1; exp_ord[2] = 4'd2; exp_ord[3] = 4'd3; exp_ord[4] = 4'd6;

    arst_n = 1'b0; i_rdy = 1'b0; clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_vld", o_rsp_vld_r, 1'b0);
    chk("rst_full", o_rsp_full_r, 1'b0);
    chk("rst_ovf", o_err_ovf_r, 1'b0);
    chk("rst_ht_vld", o_ht_wr_vld_r, 1'b0);
    arst_n = 1'b1;
    idle(1);
    i_rdy = 1'b1;

    // Single POP beat
    beat(4'd2, OP_POP, STATUS_OK, 1'b1, 1'b1, a5);
    clr();
    chk("pop_c1_ht", o_ht_wr_vld_r, 1'b1);
    chk("pop_c1_done", o_eng_done_vld_r, 1'b1);
    chk("pop_c1_done_engid", o_eng_done_engid_r, 4'd2);
    chk("pop_c1_no_bypass", o_rsp_vld_r, 1'b0);
    @(posedge clk); #1;
    chk("pop_c2_rsp_vld", o_rsp_vld_r, 1'b1);
    chk("pop_c2_dat_vld", o_rsp_dat_vld_r, 1'b1);
    chk("pop_c2_dat", o_rsp_dat_r, a5);
    chk("pop_c2_engid", o_rsp_engid_r, 4'd2);
    @(posedge clk); #1;
    chk("pop_c3_rsp_vld", o_rsp_vld_r, 1'b0);
    chk("pop_one_rsp", acc_q.size(), 1);

    // PUSH with 3 beats, garbage on dat that must not reach the response
    idle(2);
    ht_base = ht_cnt;
    beat(4'd7, OP_PUSH, STATUS_OK, 1'b0, 1'b0, 128'hDEAD_BEEF);
    beat(4'd7, OP_PUSH, STATUS_OK, 1'b0, 1'b0, 128'h1234);
    beat(4'd7, OP_PUSH, STATUS_OK, 1'b1, 1'b0, 128'h5678);
    idle(4);
    chk("push_ht_pulses", ht_cnt - ht_base, 3);
    chk("push_one_rsp", acc_q.size(), 2);
    chk("push_rsp_dat_vld", acc_q[1].dat_vld, 1'b0);
    chk("push_rsp_dat", acc_q[1].dat, 128'h0);

    // Non-OK status
    beat(4'd5, OP_POP, STATUS_ERR, 1'b1, 1'b0, 128'h0);
    clr();
    chk("err_c1_ht", o_ht_wr_vld_r, 1'b0);
    chk("err_c1_done", o_eng_done_vld_r, 1'b1);
    idle(3);
    chk("err_rsp_cnt", acc_q.size(), 3);
    chk("err_rsp_status", acc_q[2].status, STATUS_ERR);

    // Fill with rdy low
    i_rdy = 1'b0;
    for (int e = 0; e < 4; e++) beat(engid_t'(e), OP_PEEK, STATUS_OK, 1'b1, 1'b1, 128'(e + 100));
    idle(2);
    chk("fill_full", o_rsp_full_r, 1'b1);
    chk("fill_ovf", o_err_ovf_r, 1'b0);

    // Push while full with a same-cycle pop
    beat(4'd6, OP_PUSH, STATUS_OK, 1'b1, 1'b0, 128'h0);
    clr();
    i_rdy = 1'b1;
    @(posedge clk); #1;
    i_rdy = 1'b0;
    chk("pp_ovf", o_err_ovf_r, 1'b0);
    chk("pp_full", o_rsp_full_r, 1'b1);
    idle(2);

    // Push while full, no pop: dropped, sticky error
    beat(4'd9, OP_PUSH, STATUS_OK, 1'b1, 1'b0, 128'h0);
    idle(2);
    chk("ovf_set", o_err_ovf_r, 1'b1);
    idle(3);
    chk("ovf_sticky", o_err_ovf_r, 1'b1);

    // Drain
    i_rdy = 1'b1;
    idle(6);
    i_rdy = 1'b0;
    chk("drain_cnt", acc_q.size(), 8);
    for (int k = 0; k < 5; k++)
      if (acc_q.size() > 3 + k) chk("drain_order", acc_q[3 + k].engid, exp_ord[k]);
    chk("drain_empty", o_rsp_vld_r, 1'b0);

    // Reset with 3 entries queued
    for (int e = 10; e < 13; e++) beat(engid_t'(e), OP_POP, STATUS_OK, 1'b1, 1'b1, 128'(e));
    idle(2);
    chk("pre_rst_vld", o_rsp_vld_r, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    chk("async_rst_vld", o_rsp_vld_r, 1'b0);
    chk("async_rst_ovf", o_err_ovf_r, 1'b0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    idle(1);
    beat(4'd13, OP_POP, STATUS_OK, 1'b1, 1'b1, 128'hC0FFEE);
    clr();
    chk("post_rst_c1_vld", o_rsp_vld_r, 1'b0);
    @(posedge clk); #1;
    chk("post_rst_c2_vld", o_rsp_vld_r, 1'b1);
    chk("post_rst_c2_engid", o_rsp_engid_r, 4'd13);
    chk("post_rst_c2_dat", o_rsp_dat_r, 128'hC0FFEE);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
